// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_pkg : shared state encoding and BCD constants for the serial add/sub
// Rev 1.0
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit_adder : combinational single-digit BCD add with carry in/out
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] d_o,
  output logic       c_o
);

  logic [4:0] sum;

  // Max 9+9+1=19, so a single +6 correction always yields a valid digit.
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    if (sum > {1'b0, BCD_MAX}) begin
      d_o = sum[3:0] + BCD_ADJ;
      c_o = 1'b1;
    end else begin
      d_o = sum[3:0];
      c_o = 1'b0;
    end
  end

endmodule : bcd_digit_adder
`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_serial_addsub : digit-serial BCD add/subtract, LSD first, with a
//                     recomplement pass producing sign-magnitude on a<b
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                carry,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          c_q, c_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;

  logic          bad_digit;
  logic [3:0]    add_a, add_b, add_d;
  logic          add_co;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
    end
  end

  // RUN adds a + (sub ? 9's-comp b : b); FIX adds 9's-comp of the result to the carry.
  always_comb begin
    if (state_q == FIX) begin
      add_a = BCD_MAX - res_q[4*idx_q +: 4];
      add_b = 4'd0;
    end else begin
      add_a = a_q[4*idx_q +: 4];
      add_b = sub_q ? (BCD_MAX - b_q[4*idx_q +: 4]) : b_q[4*idx_q +: 4];
    end
  end

  bcd_digit_adder u_digit_adder (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (c_q),
    .d_o (add_d),
    .c_o (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          c_d     = sub;
          res_d   = '0;
          carry_d = 1'b0;
          neg_d   = 1'b0;
          err_d   = bad_digit;
          state_d = bad_digit ? DONE : RUN;
        end
      end
      RUN: begin
        res_d[4*idx_q +: 4] = add_d;
        c_d   = add_co;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (!sub_q) begin
            carry_d = add_co;
            state_d = DONE;
          end else if (add_co) begin
            neg_d   = 1'b0;
            state_d = DONE;
          end else begin
            neg_d   = 1'b1;
            c_d     = 1'b1;
            state_d = FIX;
          end
        end
      end
      FIX: begin
        res_d[4*idx_q +: 4] = add_d;
        c_d   = add_co;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign neg       = neg_q;
  assign err       = err_q;

endmodule : bcd_serial_addsub
`default_nettype wire
